// File: rtl/ahb_master.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_master (with ahb_master_pkg)
//  Description : Single-master AHB-Lite bus master. Converts local command
//                requests into SINGLE or INCR4 word transfers, honours wait
//                states, terminates bursts on an error response and returns
//                read beats plus a completion status to the requester.
//  Revision    : 1.0 - initial release
// ============================================================================

package ahb_master_pkg;
    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } trans_t;
endpackage

module ahb_master
    import ahb_master_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               HCLK,
    input  logic               HRESETn,
    // local command interface
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic               cmd_burst,
    input  logic [WIDTH-1:0]   cmd_addr,
    input  logic [4*WIDTH-1:0] cmd_wdata,
    output logic               rd_valid,
    output logic [WIDTH-1:0]   rd_data,
    output logic               done,
    output logic               err,
    // AHB-Lite master interface
    output logic [WIDTH-1:0]   HADDR,
    output logic               HWRITE,
    output logic [2:0]         HSIZE,
    output logic [2:0]         HBURST,
    output logic [3:0]         HPROT,
    output trans_t             HTRANS,
    output logic               HMASTLOCK,
    output logic [WIDTH-1:0]   HWDATA,
    input  logic               HREADY,
    input  logic               HRESP,
    input  logic [WIDTH-1:0]   HRDATA
);

    localparam logic [1:0]       c_ST_IDLE      = 2'd0;
    localparam logic [1:0]       c_ST_ADDR      = 2'd1;
    localparam logic [1:0]       c_ST_DATA_LAST = 2'd2;
    localparam logic [1:0]       c_ST_ERR       = 2'd3;

    localparam logic [WIDTH-1:0] c_BEAT_BYTES   = WIDTH'(4);
    localparam logic [2:0]       c_HSIZE_WORD   = 3'b010;
    localparam logic [2:0]       c_HBURST_SINGLE = 3'b000;
    localparam logic [2:0]       c_HBURST_INCR4 = 3'b011;
    localparam logic [3:0]       c_HPROT_DATA   = 4'b0011;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [1:0]       r_beat;          // beat currently in its address phase
    logic             r_burst;
    logic             r_write;
    logic [WIDTH-1:0] r_addr;
    logic [WIDTH-1:0] r_wbuf [4];
    logic             r_dphase;        // a data phase is in progress
    logic [WIDTH-1:0] r_hwdata;
    logic             r_rd_valid;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_done;
    logic             r_err;

    trans_t           w_htrans;
    logic             w_cmd_ready;
    logic             w_accept;
    logic             w_data_err;
    logic             w_last_beat;
    logic             w_addr_adv;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic             w_rd_capture;
    logic             w_unused_addr_lsbs;

    // Byte-lane bits of the start address are discarded: transfers are words.
    assign w_unused_addr_lsbs = ^cmd_addr[1:0];

    assign w_data_err   = r_dphase & HRESP;
    assign w_last_beat  = (r_beat == (r_burst ? 2'd3 : 2'd0));
    assign w_accept     = w_cmd_ready & cmd_valid;
    assign w_addr_adv   = (r_state == c_ST_ADDR) & HREADY & ~w_data_err;
    assign w_rd_capture = r_dphase & HREADY & ~HRESP & ~r_write;

    // Transfer sequencing: next state, transfer type and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_htrans    = HTRANS_IDLE;
        w_cmd_ready = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                // stays busy for the cycle in which done is shown
                w_cmd_ready = ~r_done;
                if (w_cmd_ready && cmd_valid) begin
                    w_state_nxt = c_ST_ADDR;
                end
            end
            c_ST_ADDR: begin
                w_htrans = (r_beat == 2'd0) ? HTRANS_NONSEQ : HTRANS_SEQ;
                if (w_data_err) begin
                    w_state_nxt = c_ST_ERR;
                end else if (HREADY && w_last_beat) begin
                    w_state_nxt = c_ST_DATA_LAST;
                end
            end
            c_ST_DATA_LAST: begin
                if (w_data_err) begin
                    w_state_nxt = c_ST_ERR;
                end else if (HREADY) begin
                    w_state_nxt = c_ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            c_ST_ERR: begin
                if (HREADY) begin
                    w_state_nxt = c_ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_err_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command capture and address-phase progression (address held on stall).
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_addr  <= '0;
            r_beat  <= 2'd0;
            r_burst <= 1'b0;
            r_write <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                r_wbuf[k] <= '0;
            end
        end else if (w_accept) begin
            r_addr  <= {cmd_addr[WIDTH-1:2], 2'b00};
            r_beat  <= 2'd0;
            r_burst <= cmd_burst;
            r_write <= cmd_write;
            for (int k = 0; k < 4; k++) begin
                r_wbuf[k] <= cmd_wdata[k*WIDTH +: WIDTH];
            end
        end else if (w_addr_adv && !w_last_beat) begin
            r_addr <= r_addr + c_BEAT_BYTES;   // wraps modulo 2^WIDTH
            r_beat <= r_beat + 2'd1;
        end
    end

    // Data-phase tracking: write data launches when its address is accepted
    // and is held until the next address is accepted.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dphase <= 1'b0;
            r_hwdata <= '0;
        end else if (w_addr_adv) begin
            r_dphase <= 1'b1;
            r_hwdata <= r_wbuf[r_beat];
        end else if (w_data_err || (r_dphase && HREADY)) begin
            r_dphase <= 1'b0;
        end
    end

    // Read return and completion status, all registered.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_capture;
            if (w_rd_capture) begin
                r_rd_data <= HRDATA;
            end
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign cmd_ready = w_cmd_ready;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign done      = r_done;
    assign err       = r_err;

    assign HADDR     = r_addr;
    assign HWRITE    = r_write;
    assign HSIZE     = c_HSIZE_WORD;
    assign HBURST    = r_burst ? c_HBURST_INCR4 : c_HBURST_SINGLE;
    assign HPROT     = c_HPROT_DATA;
    assign HTRANS    = w_htrans;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = r_hwdata;

endmodule

`default_nettype wire

// File: tb/tb_ahb_master.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ahb_master
//  Description : Self-checking bench for ahb_master. A beat-level timeline
//                model predicts every bus and local-side output per cycle
//                from the command and the slave's wait/error schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_master;
    import ahb_master_pkg::*;

    localparam int MAXC = 64;

    logic         HCLK = 1'b0;
    logic         HRESETn;
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_write;
    logic         cmd_burst;
    logic [31:0]  cmd_addr;
    logic [127:0] cmd_wdata;
    logic         rd_valid;
    logic [31:0]  rd_data;
    logic         done;
    logic         err;
    logic [31:0]  HADDR;
    logic         HWRITE;
    logic [2:0]   HSIZE;
    logic [2:0]   HBURST;
    logic [3:0]   HPROT;
    trans_t       HTRANS;
    logic         HMASTLOCK;
    logic [31:0]  HWDATA;
    logic         HREADY;
    logic         HRESP;
    logic [31:0]  HRDATA;

    ahb_master #(.WIDTH(32)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_burst(cmd_burst), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done), .err(err),
        .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    always #5 HCLK = ~HCLK;

    int checks = 0;
    int errors = 0;
    int cur_t  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cur_t, act, exp);
        end
    endtask

    // Slave schedule: wait cycles per beat and the beat that errors (-1 none).
    int          g_w [4];
    int          g_eb;

    // Per-cycle predictions (index = cycles after command acceptance).
    logic [1:0]  e_trans [MAXC];
    logic [31:0] e_addr  [MAXC];
    logic        e_wdv   [MAXC];
    logic [31:0] e_wd    [MAXC];
    logic        e_rdv   [MAXC];
    logic [31:0] e_rd    [MAXC];
    logic        s_rdy   [MAXC];
    logic        s_resp  [MAXC];
    logic        s_rdv   [MAXC];
    logic [31:0] s_rdata [MAXC];
    int          e_tdone;
    logic        e_err;

    // Beat timeline: beat 0 address in cycle 1; the data phase of beat k lasts
    // its waits plus one ready cycle and overlaps beat k+1's address phase.
    task automatic build_model(input logic wr, input logic bst,
                               input logic [31:0] a, input logic [127:0] wd);
        int n, stop, d, w;
        logic [31:0] base;
        base = {a[31:2], 2'b00};
        for (int c = 0; c < MAXC; c++) begin
            e_trans[c] = 2'b00; e_addr[c] = '0; e_wdv[c] = 1'b0; e_wd[c] = '0;
            e_rdv[c] = 1'b0; e_rd[c] = '0; s_rdy[c] = 1'b1; s_resp[c] = 1'b0;
            s_rdv[c] = 1'b0; s_rdata[c] = '0;
        end
        n     = bst ? 4 : 1;
        e_err = (g_eb >= 0) && (g_eb < n);
        stop  = e_err ? g_eb : n - 1;
        e_trans[1] = 2'b10;
        e_addr[1]  = base;
        d = 2;
        for (int k = 0; k <= stop; k++) begin
            w = g_w[k];
            if (k + 1 < n) begin
                for (int c = d; c <= d + w; c++) begin
                    e_trans[c] = 2'b11;
                    e_addr[c]  = base + 32'(4 * (k + 1));
                end
            end
            for (int c = d; c < d + w; c++) s_rdy[c] = 1'b0;
            if (wr) begin
                for (int c = d; c <= d + w + ((e_err && k == stop) ? 1 : 0); c++) begin
                    e_wdv[c] = 1'b1;
                    e_wd[c]  = wd[k*32 +: 32];
                end
            end
            if (e_err && k == stop) begin
                s_rdy[d+w] = 1'b0; s_resp[d+w] = 1'b1;
                s_rdy[d+w+1] = 1'b1; s_resp[d+w+1] = 1'b1;
                e_tdone = d + w + 2;
            end else begin
                s_rdv[d+w]   = 1'b1;
                s_rdata[d+w] = $urandom;
                if (!wr) begin
                    e_rdv[d+w+1] = 1'b1;
                    e_rd[d+w+1]  = s_rdata[d+w];
                end
                d = d + w + 1;
            end
        end
        if (!e_err) e_tdone = d;
    endtask

    // Issue one command and check every cycle up to the one after done.
    task automatic run_cmd(input logic wr, input logic bst, input logic [31:0] a,
                           input logic [127:0] wd, output int o_done,
                           output logic o_err, output logic [31:0] o_last,
                           output int o_wait);
        build_model(wr, bst, a, wd);
        o_wait = 0;
        while (cmd_ready !== 1'b1 && o_wait < 20) begin
            @(negedge HCLK);
            o_wait++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_burst = bst;
        cmd_addr = a; cmd_wdata = wd;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = $urandom;
        o_done = -1; o_err = 1'b0; o_last = '0;
        for (int t = 1; t <= e_tdone + 1; t++) begin
            @(negedge HCLK);
            cur_t = t;
            cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_burst = 1'($urandom);
            cmd_addr = $urandom; cmd_wdata = {$urandom, $urandom, $urandom, $urandom};
            chk("cmd_ready", cmd_ready, t > e_tdone);
            chk("htrans", HTRANS, e_trans[t]);
            if (e_trans[t] != 2'b00) begin
                chk("haddr", HADDR, e_addr[t]);
                chk("hwrite", HWRITE, wr);
                chk("hburst", HBURST, bst ? 3'b011 : 3'b000);
                o_last = HADDR;
            end
            if (e_wdv[t]) chk("hwdata", HWDATA, e_wd[t]);
            chk("rd_valid", rd_valid, e_rdv[t]);
            if (e_rdv[t]) chk("rd_data", rd_data, e_rd[t]);
            chk("done", done, t == e_tdone);
            if (t == e_tdone) chk("err", err, e_err);
            if (done === 1'b1) begin
                o_done = t;
                o_err  = err;
            end
            if (t == 1) begin
                chk("hsize", HSIZE, 3'b010);
                chk("hprot", HPROT, 4'b0011);
                chk("hmastlock", HMASTLOCK, 0);
            end
            HREADY = s_rdy[t];
            HRESP  = s_resp[t];
            HRDATA = s_rdv[t] ? s_rdata[t] : $urandom;
        end
    endtask

    typedef struct {
        logic         wr;
        logic         bst;
        logic [31:0]  addr;
        logic [127:0] wd;
        int           w0, w1, w2, w3;
        int           eb;
        int           exp_done;
        logic         exp_err;
        logic [31:0]  exp_last;
    } vec_t;

    vec_t vt [10];

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          od, ow, n;
        logic        oe;
        logic [31:0] ol, ra;

        vt[0] = '{1'b1, 1'b0, 32'h0000_0024, 128'hDEADBEEF, 0, 0, 0, 0, -1, 3, 1'b0, 32'h0000_0024};
        vt[1] = '{1'b0, 1'b1, 32'h0000_0040, 128'h0, 0, 0, 2, 0, -1, 8, 1'b0, 32'h0000_004C};
        vt[2] = '{1'b1, 1'b1, 32'h0000_0100, 128'h44444444_33333333_22222222_11111111,
                  0, 0, 0, 0, 1, 5, 1'b1, 32'h0000_0108};
        vt[3] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 128'h0, 0, 0, 0, 0, -1, 6, 1'b0, 32'h0000_0004};
        vt[4] = '{1'b0, 1'b0, 32'h0000_0080, 128'h0, 0, 0, 0, 0, -1, 3, 1'b0, 32'h0000_0080};
        vt[5] = '{1'b0, 1'b0, 32'h0000_1003, 128'h0, 3, 0, 0, 0, -1, 6, 1'b0, 32'h0000_1000};
        vt[6] = '{1'b1, 1'b1, 32'h0000_2000, 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0,
                  1, 0, 2, 1, -1, 10, 1'b0, 32'h0000_200C};
        vt[7] = '{1'b0, 1'b1, 32'h0000_3000, 128'h0, 0, 0, 0, 1, 3, 8, 1'b1, 32'h0000_300C};
        vt[8] = '{1'b0, 1'b1, 32'h0000_4000, 128'h0, 0, 0, 0, 0, 0, 4, 1'b1, 32'h0000_4004};
        vt[9] = '{1'b1, 1'b0, 32'h0000_5000, 128'h5555AAAA, 1, 0, 0, 0, 0, 5, 1'b1, 32'h0000_5000};

        HRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_burst = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        repeat (3) @(negedge HCLK);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_htrans", HTRANS, 2'b00);
        chk("rst_haddr", HADDR, 0);
        chk("rst_hwdata", HWDATA, 0);
        chk("rst_hburst", HBURST, 0);
        chk("rst_hwrite", HWRITE, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Directed vectors, issued back to back.
        for (int i = 0; i < 10; i++) begin
            g_w[0] = vt[i].w0; g_w[1] = vt[i].w1; g_w[2] = vt[i].w2; g_w[3] = vt[i].w3;
            g_eb   = vt[i].eb;
            run_cmd(vt[i].wr, vt[i].bst, vt[i].addr, vt[i].wd, od, oe, ol, ow);
            chk("tbl_done_cycle", od, vt[i].exp_done);
            chk("tbl_err", oe, vt[i].exp_err);
            chk("tbl_last_addr", ol, vt[i].exp_last);
            chk("tbl_no_wait", ow, 0);
        end

        // Randomized commands and slave behaviour.
        for (int i = 0; i < 40; i++) begin
            logic rw, rb;
            rw = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            n  = rb ? 4 : 1;
            ra = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                             : $urandom;
            for (int k = 0; k < 4; k++) g_w[k] = $urandom_range(0, 2);
            g_eb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
            run_cmd(rw, rb, ra, {$urandom, $urandom, $urandom, $urandom}, od, oe, ol, ow);
            repeat ($urandom_range(0, 2)) begin
                @(negedge HCLK);
                chk("gap_cmd_ready", cmd_ready, 1);
                chk("gap_htrans", HTRANS, 2'b00);
            end
        end

        // Reset during beat 2 of an INCR4 read.
        g_w[0] = 0; g_w[1] = 0; g_w[2] = 0; g_w[3] = 0; g_eb = -1;
        chk("pre_rst_ready", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_burst = 1'b1;
        cmd_addr = 32'h0000_6000; cmd_wdata = '0; HREADY = 1'b1; HRESP = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            @(negedge HCLK);
            cur_t = t;
            cmd_valid = 1'b0;
            HRDATA = 32'hCAFE_0000 | 32'(t);
        end
        chk("pre_rst_htrans", HTRANS, 2'b11);
        chk("pre_rst_haddr", HADDR, 32'h0000_6008);
        HRESETn = 1'b0;
        #1;
        chk("mid_rst_htrans", HTRANS, 2'b00);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_haddr", HADDR, 0);
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_rd_data", rd_data, 0);
        chk("mid_rst_hburst", HBURST, 0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        for (int t = 0; t < 3; t++) begin
            @(negedge HCLK);
            chk("post_rst_done", done, 0);
            chk("post_rst_htrans", HTRANS, 2'b00);
        end
        run_cmd(1'b1, 1'b0, 32'h0000_7010, 128'h1234_5678, od, oe, ol, ow);
        chk("post_rst_single_done", od, 3);
        chk("post_rst_single_err", oe, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_master.md
# ahb_master

Single-master AHB-Lite bus master that turns simple command requests into AHB transfers toward the slaves on the shared bus. It sits directly upstream of the memory slaves and drives HADDR/HTRANS/HWRITE/HWDATA on their address and data phases. It supports SINGLE and INCR4 word transfers, wait states via HREADY, and error-terminated bursts via HRESP. It returns read data and a completion status to the local requester.

## Interface
- WIDTH, 32: address and data width.
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  master idle and able to accept; reset 1.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_burst  in  1  0 = SINGLE (1 beat), 1 = INCR4 (4 beats).
- cmd_addr  in  WIDTH  start byte address; bits [1:0] are ignored and forced to 0.
- cmd_wdata  in  4*WIDTH  write beats; beat k is at [k*WIDTH +: WIDTH]. SINGLE uses beat 0.
- rd_valid  out  1  one read beat on rd_data; reset 0.
- rd_data  out  WIDTH  read beat; reset 0.
- done  out  1  one-cycle completion pulse; reset 0.
- err  out  1  valid with done: 1 = transfer terminated by HRESP; reset 0.
- HADDR  out  WIDTH  reset 0.
- HWRITE  out  1  reset 0.
- HSIZE  out  3  constant 3'b010 (word).
- HBURST  out  3  3'b000 SINGLE or 3'b011 INCR4; reset 0.
- HPROT  out  4  constant 4'b0011.
- HTRANS  out  trans_t  reset IDLE.
- HMASTLOCK  out  1  constant 0.
- HWDATA  out  WIDTH  reset 0.
- HREADY  in  1  bus ready (muxed HREADYOUT).
- HRESP  in  1  bus error response.
- HRDATA  in  WIDTH  read data.

## Operation
- FSM states: IDLE, ADDR, DATA_LAST, ERR.
- IDLE: cmd_ready=1, HTRANS=IDLE. When cmd_valid is high, the master latches the command, buffers the 4 write beats, and moves to ADDR.
- ADDR: drives the address phase of beat n. Beat 0 uses NONSEQ; later beats use SEQ. HADDR = start + 4n and wraps modulo 2^WIDTH.
  - All address-phase outputs hold while HREADY=0.
  - On HREADY=1 the beat advances.
  - After the last beat's address phase is accepted, the FSM moves to DATA_LAST.
- Pipelining: the data phase of beat n overlaps the address phase of beat n+1.
  - HWDATA for beat n is driven for the whole data phase of beat n and is held through wait states.
  - Read beat n is captured from HRDATA in the cycle where HREADY=1 during its data phase.
- DATA_LAST: HTRANS=IDLE. When HREADY=1 and HRESP=0, the master pulses done (err=0) and returns to IDLE.
- Error: HRESP=1 sampled during any data phase (HREADY 0 or 1) sends the FSM to ERR.
  - The next address phase is forced to IDLE, and the remaining beats are cancelled, not retried.
  - ERR waits for HREADY=1, then pulses done with err=1 and returns to IDLE.
  - The errored read beat does not produce rd_valid.
- rd_valid is registered and pulses once per successful read beat.
- For a read, the final rd_valid coincides with done.
- Reset asserted mid-transfer immediately forces every output to its reset value. The burst is abandoned and no done pulse is generated.

## Timing
- Cycle 0: command accepted. Cycle 1: NONSEQ address phase, HBURST/HWRITE valid.
- Zero-wait SINGLE: data phase in cycle 2; done (and rd_valid for a read) in cycle 3.
- Zero-wait INCR4: address phases in cycles 1-4, data phases in cycles 2-5, done in cycle 6.
  - Read beats appear on rd_valid in cycles 3-6.
- Each wait cycle (HREADY=0) delays every subsequent event by one cycle.
- cmd_ready returns high in the cycle after done. A new command accepted in that cycle puts its NONSEQ in the following cycle.
- HTRANS is never BUSY.

## Test plan
- Single write, addr 0x24, data 0xDEADBEEF, zero wait.
  - Expect NONSEQ/HADDR 0x24/HWRITE=1 in cycle 1, HWDATA 0xDEADBEEF in cycle 2, done=1 and err=0 in cycle 3.
- INCR4 read from 0x40, slave returning 0x10..0x13, HREADY low for 2 cycles on beat 2.
  - Expect HADDR 0x40, 0x44, 0x48, 0x4C with NONSEQ, SEQ, SEQ, SEQ.
  - Address of beat 3 held during the stall; rd_data 0x10..0x13 in order; done in cycle 8.
- INCR4 write where HRESP=1 on beat 1 (HREADY=0 then HREADY=1).
  - Expect HTRANS=IDLE in the cycle after HRESP is first seen, no further beats, done=1 and err=1 one cycle after the HREADY=1 error cycle.
- INCR4 from 0xFFFFFFF8.
  - Expect HADDR 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- Back-to-back: a single read issued in the cycle after done of the previous write.
  - Expect NONSEQ one cycle later and cmd_ready=0 throughout.
- Assert HRESETn low during beat 2 of an INCR4.
  - Expect HTRANS=IDLE, cmd_ready=1, done=0 immediately, and a clean single transfer after release.
